// File: rtl/sipo_rx.sv
// sipo_rx: MSB-first serial-to-parallel receiver with one-word output hold, realign and sticky overrun.
module sipo_rx #(
  parameter int SIZE = 8
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            serial_in,
  input  logic            bit_valid_in,
  input  logic            sync_in,
  input  logic            ready_in,
  output logic [SIZE-1:0] data_out,
  output logic            valid_out,
  output logic            busy_out,
  output logic            overrun_out
);
  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
  logic [SIZE-1:0] shift_q, shift_d, data_q, data_d, word;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d, ovr_q, ovr_d, complete, accept;
  always_comb begin
    word     = {shift_q[SIZE-2:0], serial_in};
    complete = bit_valid_in && !sync_in && (cnt_q == CW'(SIZE - 1));
    accept   = complete && (!valid_q || ready_in);
    shift_d  = sync_in ? (bit_valid_in ? SIZE'(serial_in) : '0) : (bit_valid_in ? word : shift_q);
    cnt_d    = sync_in ? CW'(bit_valid_in) :
               bit_valid_in ? (complete ? '0 : cnt_q + 1'b1) : cnt_q;
    data_d   = accept ? word : data_q;
    valid_d  = accept ? 1'b1 : (valid_q && ready_in) ? 1'b0 : valid_q;
    ovr_d    = ovr_q || (complete && valid_q && !ready_in);
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign busy_out    = cnt_q != '0;
  assign overrun_out = ovr_q;
endmodule
